// File: rtl/kcalc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kcalc_sequencer
// Purpose  : Measures the reference period P in clk cycles (rise to rise of a
//            synchronised ref_in) and computes K = floor(P / mult) with a
//            serial restoring divider. K is handed to the frequency-multiplier
//            controller together with a one-cycle kcalc strobe.
// Ports    : clk    - system clock, rising edge
//            rst    - synchronous active-high reset
//            start  - begin measure-and-divide (honoured only when idle)
//            ref_in - asynchronous reference signal
//            mult   - divisor, captured when start is accepted
//            k      - last good K, held until the next successful result
//            kcalc  - one-cycle strobe, k valid in the same cycle
//            busy   - high whenever the sequencer is not idle
//            err    - sticky error (mult==0, timeout, or K==0)
// Revision : 1.0 - initial release
// ============================================================================
module kcalc_sequencer #(
    parameter int PW = 16,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ref_in,
    input  logic [MW-1:0] mult,
    output logic [PW-1:0] k,
    output logic          kcalc,
    output logic          busy,
    output logic          err
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SYNC    = 3'd1;
    localparam logic [2:0] c_ST_MEASURE = 3'd2;
    localparam logic [2:0] c_ST_DIVIDE  = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    // Iteration counter is one bit wider than strictly needed so that any PW
    // (including powers of two) fits without wrap ambiguity.
    localparam int               c_IW   = $clog2(PW) + 1;
    localparam logic [c_IW-1:0]  c_LAST = c_IW'(PW - 1);

    logic [2:0]    r_state;
    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [PW-1:0] r_cnt;
    logic [MW-1:0] r_mult;
    logic [PW-1:0] r_quo;
    logic [PW:0]   r_rem;
    logic [c_IW-1:0] r_iter;

    logic          w_rise;
    logic [PW-1:0] w_cnt_inc;
    logic          w_cnt_sat;
    logic [PW:0]   w_div;
    logic [PW:0]   w_trial;
    logic          w_ge;
    logic [PW:0]   w_rem_nxt;
    logic [PW-1:0] w_quo_nxt;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_cnt_inc = r_cnt + PW'(1);
    // Counting stops one short of all-ones: the measurement is abandoned
    // rather than allowed to wrap into a bogus small period.
    assign w_cnt_sat = (w_cnt_inc == {PW{1'b1}});

    // Restoring divider step: the dividend is shifted in MSB first through
    // r_quo, and quotient bits are shifted in at its LSB as it empties.
    // A 1 leaving the top of the remainder means the trial value certainly
    // exceeds the divisor, so it participates in the compare.
    assign w_div     = (PW + 1)'(r_mult);
    assign w_trial   = {r_rem[PW-1:0], r_quo[PW-1]};
    assign w_ge      = r_rem[PW] | (w_trial >= w_div);
    assign w_rem_nxt = w_ge ? (w_trial - w_div) : w_trial;
    assign w_quo_nxt = {r_quo[PW-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_cnt   <= '0;
            r_mult  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_iter  <= '0;
            k       <= '0;
            kcalc   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_s1  <= ref_in;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            kcalc <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (mult == '0) begin
                            err <= 1'b1;
                        end else begin
                            r_mult  <= mult;
                            err     <= 1'b0;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                            r_state <= c_ST_SYNC;
                        end
                    end
                end

                c_ST_SYNC: begin
                    if (w_rise) begin
                        r_cnt   <= PW'(1);
                        r_state <= c_ST_MEASURE;
                    end else if (w_cnt_sat) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                c_ST_MEASURE: begin
                    if (w_rise) begin
                        r_quo   <= r_cnt;
                        r_rem   <= '0;
                        r_iter  <= '0;
                        r_state <= c_ST_DIVIDE;
                    end else if (w_cnt_sat) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                c_ST_DIVIDE: begin
                    r_quo  <= w_quo_nxt;
                    r_rem  <= w_rem_nxt;
                    r_iter <= r_iter + c_IW'(1);
                    if (r_iter == c_LAST) begin
                        // k and kcalc are registered here so both are visible
                        // throughout the DONE cycle.
                        r_state <= c_ST_DONE;
                        if (w_quo_nxt != '0) begin
                            k     <= w_quo_nxt;
                            kcalc <= 1'b1;
                        end
                    end
                end

                c_ST_DONE: begin
                    // A zero quotient means P < mult; the previous K is kept.
                    if (r_quo == '0) begin
                        err <= 1'b1;
                    end
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kcalc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_kcalc_sequencer
// Purpose  : Self-checking bench for kcalc_sequencer. The reference model is
//            the arithmetic K = floor(P / mult) over the period the bench
//            itself generates, plus a tracked "last good K" value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kcalc_sequencer;

    localparam int PW = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ref_in;
    logic [MW-1:0] mult;
    logic [PW-1:0] k;
    logic          kcalc;
    logic          busy;
    logic          err;

    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_k    = 0;   // model of the held K register

    kcalc_sequencer #(.PW(PW), .MW(MW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ref_in (ref_in),
        .mult   (mult),
        .k      (k),
        .kcalc  (kcalc),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Square wave starting low, first rising edge at cycle d, one rise per period.
    function automatic logic wave(input int i, input int d, input int per);
        if (i < d) return 1'b0;
        return (((i - d) % per) < (per / 2)) ? 1'b1 : 1'b0;
    endfunction

    // One full measure-and-divide transaction. The interval between the first
    // two generated rises is the period P the DUT should measure.
    task automatic run_meas(input logic [MW-1:0] m, input int per, input int d,
                            input bit poke, input bit rst_mid, input string tag);
        int  i2;
        int  kc_n;
        int  kc_at;
        int  fall_at;
        int  limit;
        int  q;
        bit  finished;
        ref_in = 1'b0;
        start  = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        mult  = m;
        tick();
        start = 1'b0;
        mult  = MW'($urandom_range(0, 15));
        chk({tag, "_busy_on_start"}, busy, 1);
        chk({tag, "_err_clr_on_start"}, err, 0);

        i2       = d + per;
        kc_n     = 0;
        kc_at    = -1;
        fall_at  = -1;
        finished = 1'b0;
        limit    = d + 2 * per + PW + 40;
        q        = per / int'(m);

        for (int i = 0; i < limit; i++) begin
            ref_in = wave(i, d, per);
            if (poke && i > d + 1 && i < i2 + 10) begin
                start = 1'($urandom_range(0, 1));
                mult  = MW'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            if (rst_mid && i == i2 + 8) rst = 1'b1;
            tick();
            if (rst_mid && i == i2 + 8) begin
                rst = 1'b0;
                chk({tag, "_rst_k"}, k, 0);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_err"}, err, 0);
                chk({tag, "_rst_kcalc"}, kcalc, 0);
                chk({tag, "_rst_no_kcalc_before"}, kc_n, 0);
                exp_k = 0;
                return;
            end
            if (kcalc) begin
                kc_n++;
                kc_at = i;
                chk({tag, "_k_with_kcalc"}, k, q);
            end
            if (!busy) begin
                fall_at  = i;
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;

        chk({tag, "_completes"}, finished, 1);
        if (q != 0) exp_k = q;
        chk({tag, "_kcalc_count"}, kc_n, (q != 0) ? 1 : 0);
        if (q != 0) begin
            chk({tag, "_kcalc_latency"}, kc_at, i2 + 2 + PW);
            chk({tag, "_busy_fall"}, fall_at, kc_at + 1);
        end
        chk({tag, "_k"}, k, exp_k);
        chk({tag, "_err"}, err, (q == 0) ? 1 : 0);
    endtask

    initial begin
        int n;
        int kc_n;
        rst    = 1'b1;
        start  = 1'b0;
        ref_in = 1'b0;
        mult   = '0;
        repeat (3) tick();
        chk("reset_k", k, 0);
        chk("reset_kcalc", kcalc, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;
        tick();

        // Basic: P=40, mult=4 -> 10
        run_meas(4'd4, 40, 3, 1'b0, 1'b0, "t1");

        // Floor and large period
        run_meas(4'd3, 7, 2, 1'b0, 1'b0, "t2a");
        run_meas(4'd1, 1000, 5, 1'b0, 1'b0, "t2b");
        repeat (20) tick();
        chk("t2_k_held", k, 1000);

        // mult == 0 is rejected without leaving idle
        start = 1'b1;
        mult  = '0;
        tick();
        start = 1'b0;
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_k", k, exp_k);
        tick();
        chk("t3_busy_stays", busy, 0);
        run_meas(4'd3, 30, 1, 1'b0, 1'b0, "t3b");

        // No reference edge: SYNC times out
        ref_in = 1'b0;
        start  = 1'b1;
        mult   = 4'd2;
        tick();
        start = 1'b0;
        n     = 0;
        kc_n  = 0;
        while (busy && n < 70000) begin
            tick();
            n++;
            if (kcalc) kc_n++;
        end
        chk("t4_timeout_window", (n >= 65530 && n <= 65540) ? 1 : 0, 1);
        chk("t4_timeout_err", err, 1);
        chk("t4_timeout_kcalc", kc_n, 0);
        chk("t4_timeout_k", k, exp_k);

        // P < mult gives a zero quotient
        run_meas(4'd5, 3, 1, 1'b0, 1'b0, "t4b");

        // start pokes during MEASURE/DIVIDE are ignored
        run_meas(4'd7, 100, 4, 1'b1, 1'b0, "t5");

        // Reset in the middle of the divide, then a clean run
        run_meas(4'd5, 60, 2, 1'b0, 1'b1, "t6");
        run_meas(4'd6, 90, 3, 1'b0, 1'b0, "t6b");

        // Randomized transactions
        for (int r = 0; r < 10; r++) begin
            run_meas(MW'($urandom_range(1, 15)), int'($urandom_range(2, 150)),
                     int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 1'b0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
